// File: rtl/collision_tracker.sv
// collision_tracker: frame-based game-rules engine for the pixel pipeline.
//
// Accumulates ship/target and bullet/target overlaps over each frame. On the
// frame strobe it publishes the collision and shot flags, then runs the lives,
// invulnerability, BCD score and play-state (IDLE/PLAY/INVULN/OVER) logic.
//
// Optional feature: define COLLISION_TRACKER_BLINK_EN to make ship_visible
// blink every 8 frames while invulnerable. Without it the ship stays visible.
//
// Ports:
//   clk_pix         in   pixel clock, the only clock
//   rst             in   synchronous reset, active-high
//   frame           in   one-cycle strobe at the start of each frame
//   de              in   visible-region qualifier
//   start           in   level, requests a new game
//   ship_drawing    in   ship pixel active
//   bullet_drawing  in   bullet pixel active
//   target_drawing  in   per-target pixel active [TARGET_COUNT]
//   collision       out  ship/target overlap seen in the last completed frame
//   target_shot     out  targets hit by the bullet in the last completed frame
//   ship_hit        out  one-cycle pulse per lost life
//   lives_left      out  remaining lives
//   score_bcd       out  packed BCD score, least-significant digit in [3:0]
//   invulnerable    out  high while in INVULN
//   game_over       out  high while in OVER
//   ship_visible    out  ship render enable
module collision_tracker #(
    parameter int unsigned TARGET_COUNT  = 10,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned SCORE_DIGITS  = 3
) (
    input  logic                      clk_pix,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      de,
    input  logic                      start,
    input  logic                      ship_drawing,
    input  logic                      bullet_drawing,
    input  logic [TARGET_COUNT-1:0]   target_drawing,
    output logic                      collision,
    output logic [TARGET_COUNT-1:0]   target_shot,
    output logic                      ship_hit,
    output logic [3:0]                lives_left,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      invulnerable,
    output logic                      game_over,
    output logic                      ship_visible
);

    localparam logic [3:0] LivesInit  = 4'(LIVES);
    localparam logic [7:0] InvulnInit = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {StIdle, StPlay, StInvuln, StOver} state_e;

    state_e                    state_q;
    logic                      coll_acc_q;
    logic [TARGET_COUNT-1:0]   shot_acc_q;
    logic [4:0]                pending_q;
    logic [7:0]                inv_cnt_q;
`ifdef COLLISION_TRACKER_BLINK_EN
    logic [2:0]                blink_cnt_q;
`endif

    logic [4:0]                shot_count;
    logic [4:0]                pending_drain;
    logic [4*SCORE_DIGITS-1:0] score_next;
    logic                      score_sat;
    logic                      carry;

    // Number of targets shot in the frame being published.
    always_comb begin
        shot_count = '0;
        for (int i = 0; i < TARGET_COUNT; i++) begin
            shot_count = shot_count + 5'(shot_acc_q[i]);
        end
    end

    assign pending_drain = pending_q - 5'(pending_q != 5'd0);

    // BCD ripple increment; a carry out of the top digit means the score is
    // all 9s, in which case the increment is dropped.
    always_comb begin
        score_next = score_bcd;
        carry      = 1'b1;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            if (carry) begin
                if (score_bcd[4*d +: 4] == 4'd9) begin
                    score_next[4*d +: 4] = 4'd0;
                end else begin
                    score_next[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        score_sat = carry;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q      <= StIdle;
            coll_acc_q   <= 1'b0;
            shot_acc_q   <= '0;
            pending_q    <= '0;
            inv_cnt_q    <= '0;
            collision    <= 1'b0;
            target_shot  <= '0;
            ship_hit     <= 1'b0;
            lives_left   <= LivesInit;
            score_bcd    <= '0;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
            ship_visible <= 1'b0;
`ifdef COLLISION_TRACKER_BLINK_EN
            blink_cnt_q  <= '0;
`endif
        end else begin
            ship_hit <= 1'b0;

            if (frame) begin
                coll_acc_q <= 1'b0;
                shot_acc_q <= '0;
            end else if (de) begin
                coll_acc_q <= coll_acc_q | (ship_drawing & (|target_drawing));
                shot_acc_q <= shot_acc_q | ({TARGET_COUNT{bullet_drawing}} & target_drawing);
            end

            // Score drain runs in every state so a game-ending frame still scores.
            pending_q <= pending_drain;
            if (pending_q != 5'd0 && !score_sat) begin
                score_bcd <= score_next;
            end

            // Outside PLAY/INVULN the published flags are forced low.
            if (frame) begin
                collision   <= 1'b0;
                target_shot <= '0;
            end

            unique case (state_q)
                StIdle, StOver: begin
                    // start beats a coincident frame: nothing is published.
                    if (start) begin
                        state_q      <= StPlay;
                        coll_acc_q   <= 1'b0;
                        shot_acc_q   <= '0;
                        pending_q    <= '0;
                        inv_cnt_q    <= '0;
                        collision    <= 1'b0;
                        target_shot  <= '0;
                        lives_left   <= LivesInit;
                        score_bcd    <= '0;
                        invulnerable <= 1'b0;
                        game_over    <= 1'b0;
                        ship_visible <= 1'b1;
                    end
                end
                StPlay, StInvuln: begin
                    if (frame) begin
                        collision   <= coll_acc_q;
                        target_shot <= shot_acc_q;
                        pending_q   <= pending_drain + shot_count;
                        if (state_q == StPlay) begin
                            if (coll_acc_q) begin
                                ship_hit   <= 1'b1;
                                lives_left <= lives_left - 4'd1;
                                if (lives_left == 4'd1) begin
                                    state_q      <= StOver;
                                    game_over    <= 1'b1;
                                    ship_visible <= 1'b0;
                                end else if (INVULN_FRAMES != 0) begin
                                    state_q      <= StInvuln;
                                    inv_cnt_q    <= InvulnInit;
                                    invulnerable <= 1'b1;
`ifdef COLLISION_TRACKER_BLINK_EN
                                    ship_visible <= 1'b0;
                                    blink_cnt_q  <= '0;
`endif
                                end
                            end
                        end else begin
                            // Collisions are ignored here, including the expiring frame.
                            inv_cnt_q <= inv_cnt_q - 8'd1;
                            if (inv_cnt_q == 8'd1) begin
                                state_q      <= StPlay;
                                invulnerable <= 1'b0;
                                ship_visible <= 1'b1;
                            end else begin
`ifdef COLLISION_TRACKER_BLINK_EN
                                blink_cnt_q <= blink_cnt_q + 3'd1;
                                if (blink_cnt_q == 3'd7) begin
                                    ship_visible <= ~ship_visible;
                                end
`endif
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_tracker.sv
module tb_collision_tracker;

    logic       clk_pix = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 1'b0;
    logic       de = 1'b0;
    logic       start = 1'b0;
    logic       ship_drawing = 1'b0;
    logic       bullet_drawing = 1'b0;
    logic [9:0] target_drawing = '0;
    logic       collision;
    logic [9:0] target_shot;
    logic       ship_hit;
    logic [3:0] lives_left;
    logic [11:0] score_bcd;
    logic       invulnerable;
    logic       game_over;
    logic       ship_visible;

    int total = 0;
    int bad = 0;

    collision_tracker #(
        .TARGET_COUNT (10),
        .LIVES        (3),
        .INVULN_FRAMES(4),
        .SCORE_DIGITS (3)
    ) dut (
        .clk_pix       (clk_pix),
        .rst           (rst),
        .frame         (frame),
        .de            (de),
        .start         (start),
        .ship_drawing  (ship_drawing),
        .bullet_drawing(bullet_drawing),
        .target_drawing(target_drawing),
        .collision     (collision),
        .target_shot   (target_shot),
        .ship_hit      (ship_hit),
        .lives_left    (lives_left),
        .score_bcd     (score_bcd),
        .invulnerable  (invulnerable),
        .game_over     (game_over),
        .ship_visible  (ship_visible)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n cycles of drawing with the given qualifier, then one blank cycle.
    task automatic paint(input logic q, input logic s, input logic b, input logic [9:0] t,
                         input int n);
        de = q; ship_drawing = s; bullet_drawing = b; target_drawing = t;
        repeat (n) tick();
        de = 1'b0; ship_drawing = 1'b0; bullet_drawing = 1'b0; target_drawing = '0;
        tick();
    endtask

    task automatic strobe();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_lives", 32'(lives_left), 32'd3);
        check("rst_score", 32'(score_bcd), 32'h000);
        check("rst_coll", 32'(collision), 32'd0);
        check("rst_shot", 32'(target_shot), 32'd0);
        check("rst_hit", 32'(ship_hit), 32'd0);
        check("rst_inv", 32'(invulnerable), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_vis", 32'(ship_visible), 32'd0);
        rst = 1'b0;
        tick();

        // Overlap while IDLE is not published
        paint(1'b1, 1'b1, 1'b1, 10'h008, 3);
        strobe();
        check("idle_coll", 32'(collision), 32'd0);
        check("idle_shot", 32'(target_shot), 32'd0);

        // start coincident with frame: accumulations discarded
        paint(1'b1, 1'b1, 1'b0, 10'h008, 2);
        start = 1'b1; frame = 1'b1;
        tick();
        start = 1'b0; frame = 1'b0;
        check("start_vis", 32'(ship_visible), 32'd1);
        check("start_lives", 32'(lives_left), 32'd3);
        strobe();
        check("start_disc_coll", 32'(collision), 32'd0);
        check("start_disc_lives", 32'(lives_left), 32'd3);

        // Overlap without de is not accumulated
        paint(1'b0, 1'b1, 1'b1, 10'h008, 3);
        strobe();
        check("no_de_coll", 32'(collision), 32'd0);
        check("no_de_shot", 32'(target_shot), 32'd0);

        // Start and hit: ship overlaps target 3
        paint(1'b1, 1'b1, 1'b0, 10'h008, 3);
        strobe();
        check("hit_coll", 32'(collision), 32'd1);
        check("hit_pulse", 32'(ship_hit), 32'd1);
        check("hit_lives", 32'(lives_left), 32'd2);
        check("hit_inv", 32'(invulnerable), 32'd1);
        check("hit_vis", 32'(ship_visible), 32'd1);
        tick();
        check("hit_pulse_end", 32'(ship_hit), 32'd0);

        // Invulnerability window: 4 overlapping frames are ignored
        for (int k = 0; k < 4; k++) begin
            paint(1'b1, 1'b1, 1'b0, 10'h008, 2);
            strobe();
            check("inv_lives", 32'(lives_left), 32'd2);
            check("inv_nohit", 32'(ship_hit), 32'd0);
        end
        check("inv_expired", 32'(invulnerable), 32'd0);
        paint(1'b1, 1'b1, 1'b0, 10'h008, 2);
        strobe();
        check("hit2_lives", 32'(lives_left), 32'd1);
        check("hit2_pulse", 32'(ship_hit), 32'd1);
        check("hit2_inv", 32'(invulnerable), 32'd1);
        for (int k = 0; k < 4; k++) begin
            paint(1'b1, 1'b0, 1'b0, 10'h000, 2);
            strobe();
        end
        check("inv2_expired", 32'(invulnerable), 32'd0);

        // Multi-target shot: targets 0, 5 and 9
        paint(1'b1, 1'b0, 1'b1, 10'b1000100001, 3);
        strobe();
        check("multi_shot", 32'(target_shot), 32'h221);
        check("multi_coll", 32'(collision), 32'd0);
        check("multi_score0", 32'(score_bcd), 32'h000);
        tick();
        tick();
        check("multi_score2", 32'(score_bcd), 32'h002);
        tick();
        check("multi_score3", 32'(score_bcd), 32'h003);
        check("multi_shot_held", 32'(target_shot), 32'h221);
        paint(1'b1, 1'b0, 1'b0, 10'h000, 2);
        strobe();
        check("multi_shot_clear", 32'(target_shot), 32'h000);

        // Preset to 998: 99 frames of 10 shots plus one of 5
        for (int k = 0; k < 99; k++) begin
            paint(1'b1, 1'b0, 1'b1, 10'h3FF, 2);
            strobe();
            repeat (10) tick();
        end
        check("score_993", 32'(score_bcd), 32'h993);
        paint(1'b1, 1'b0, 1'b1, 10'h01F, 2);
        strobe();
        repeat (10) tick();
        check("score_998", 32'(score_bcd), 32'h998);
        paint(1'b1, 1'b0, 1'b1, 10'h00F, 2);
        strobe();
        repeat (6) tick();
        check("score_sat", 32'(score_bcd), 32'h999);

        // Third life lost -> game over
        paint(1'b1, 1'b1, 1'b1, 10'h003, 2);
        strobe();
        check("over_lives", 32'(lives_left), 32'd0);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_vis", 32'(ship_visible), 32'd0);
        check("over_pulse", 32'(ship_hit), 32'd1);
        check("over_inv", 32'(invulnerable), 32'd0);
        paint(1'b1, 1'b1, 1'b1, 10'h003, 2);
        strobe();
        check("over_coll_forced", 32'(collision), 32'd0);
        check("over_shot_forced", 32'(target_shot), 32'd0);
        check("over_score_kept", 32'(score_bcd), 32'h999);

        // Restart from OVER
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_lives", 32'(lives_left), 32'd3);
        check("restart_score", 32'(score_bcd), 32'h000);
        check("restart_over", 32'(game_over), 32'd0);
        check("restart_vis", 32'(ship_visible), 32'd1);

        // Reset one cycle after a publish with 5 pending
        paint(1'b1, 1'b0, 1'b1, 10'h01F, 2);
        strobe();
        check("drain_shot", 32'(target_shot), 32'h01F);
        tick();
        check("drain_score1", 32'(score_bcd), 32'h001);
        rst = 1'b1;
        tick();
        check("mid_rst_score", 32'(score_bcd), 32'h000);
        check("mid_rst_shot", 32'(target_shot), 32'd0);
        check("mid_rst_lives", 32'(lives_left), 32'd3);
        check("mid_rst_vis", 32'(ship_visible), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("pending_lost", 32'(score_bcd), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
